// File: rtl/systolic_array_driver.sv
// Systolic array driver: loads A/B, optionally clears C, feeds skewed operands, drains C rows.
// Define SA_DRV_CLR_EN to clear C before each feed; otherwise C accumulates across jobs.

module sa_skew_lane #(
  parameter int BITS = 8,
  parameter int DIM  = 8,
  parameter int LANE = 0,
  parameter int KW   = 5
) (
  input  logic                     en,
  input  logic [KW-1:0]            k,
  input  logic [DIM-1:0][BITS-1:0] vec,
  output logic [BITS-1:0]          y
);
  localparam int RB = (DIM > 1) ? $clog2(DIM) : 1;
  logic [KW-1:0] off;

  always_comb begin
    off = k - KW'(LANE);
    y   = '0;
    if (en && (k >= KW'(LANE)) && (off < KW'(DIM))) y = vec[off[RB-1:0]];
  end
endmodule

module systolic_array_driver #(
  parameter  int BITS_AB = 8,
  parameter  int BITS_C  = 16,
  parameter  int DIM     = 8,
  localparam int ROWBITS = $clog2(DIM)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ld_valid,
  input  logic                        ld_sel,
  input  logic [ROWBITS-1:0]          ld_row,
  input  logic [DIM-1:0][BITS_AB-1:0] ld_data,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        sa_en,
  output logic                        sa_WrEn,
  output logic [ROWBITS-1:0]          sa_Crow,
  output logic [DIM-1:0][BITS_AB-1:0] sa_A,
  output logic [DIM-1:0][BITS_AB-1:0] sa_B,
  output logic [DIM-1:0][BITS_C-1:0]  sa_Cin,
  input  logic [DIM-1:0][BITS_C-1:0]  sa_Cout,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [ROWBITS-1:0]          res_row,
  output logic [DIM-1:0][BITS_C-1:0]  res_data
);
  localparam int KW = $clog2(3*DIM);

  typedef enum logic [2:0] {IDLE, CLR, FEED, DRAIN_ADDR, DRAIN_OUT, DONE} state_t;

  state_t                                 state_q, state_d;
  logic [KW-1:0]                          cnt_q, cnt_d;
  logic [ROWBITS-1:0]                     row_q, row_d;
  logic [DIM-1:0][DIM-1:0][BITS_AB-1:0]   a_q, a_d, b_q, b_d, b_col;

  logic                                   busy_q, busy_d, done_q, done_d;
  logic                                   en_q, en_d, wren_q, wren_d, rv_q, rv_d;
  logic [ROWBITS-1:0]                     crow_q, crow_d, rrow_q, rrow_d;
  logic [DIM-1:0][BITS_AB-1:0]            sa_a_q, sa_a_d, sa_b_q, sa_b_d;
  logic [DIM-1:0][BITS_C-1:0]             cin_q, cin_d, rdata_q, rdata_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (ld_valid) begin
          if (ld_sel) b_d[ld_row] = ld_data;
          else        a_d[ld_row] = ld_data;
        end
        if (start) begin
          cnt_d = '0;
          row_d = '0;
`ifdef SA_DRV_CLR_EN
          state_d = CLR;
`else
          state_d = FEED;
`endif
        end
      end
      CLR: begin
        if (cnt_q == KW'(DIM-1)) begin
          cnt_d   = '0;
          state_d = FEED;
        end else cnt_d = cnt_q + KW'(1);
      end
      FEED: begin
        if (cnt_q == KW'(3*DIM-2)) begin
          row_d   = '0;
          state_d = DRAIN_ADDR;
        end else cnt_d = cnt_q + KW'(1);
      end
      DRAIN_ADDR: state_d = DRAIN_OUT;
      DRAIN_OUT: begin
        if (rv_q && res_ready) begin
          if (row_q == ROWBITS'(DIM-1)) state_d = DONE;
          else begin
            row_d   = row_q + ROWBITS'(1);
            state_d = DRAIN_ADDR;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight off a flop.
  always_comb begin
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    wren_d  = (state_d == CLR);
    en_d    = (state_d == FEED);
    rv_d    = (state_d == DRAIN_OUT);
    cin_d   = '0;
    crow_d  = '0;
    case (state_d)
      CLR:                   crow_d = cnt_d[ROWBITS-1:0];
      DRAIN_ADDR, DRAIN_OUT: crow_d = row_d;
      default:               crow_d = '0;
    endcase
    rrow_d  = rrow_q;
    rdata_d = rdata_q;
    if (state_q == DRAIN_ADDR) begin
      rdata_d = sa_Cout;
      rrow_d  = row_q;
    end
  end

  // Skew muxes read the next-cycle matrices so a load coincident with start is honoured.
  for (genvar g = 0; g < DIM; g++) begin : g_lane
    for (genvar i = 0; i < DIM; i++) begin : g_col
      assign b_col[g][i] = b_d[i][g];
    end
    sa_skew_lane #(.BITS(BITS_AB), .DIM(DIM), .LANE(g), .KW(KW)) u_a (
      .en(en_d), .k(cnt_d), .vec(a_d[g]), .y(sa_a_d[g])
    );
    sa_skew_lane #(.BITS(BITS_AB), .DIM(DIM), .LANE(g), .KW(KW)) u_b (
      .en(en_d), .k(cnt_d), .vec(b_col[g]), .y(sa_b_d[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      wren_q  <= 1'b0;
      rv_q    <= 1'b0;
      crow_q  <= '0;
      rrow_q  <= '0;
      sa_a_q  <= '0;
      sa_b_q  <= '0;
      cin_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      en_q    <= en_d;
      wren_q  <= wren_d;
      rv_q    <= rv_d;
      crow_q  <= crow_d;
      rrow_q  <= rrow_d;
      sa_a_q  <= sa_a_d;
      sa_b_q  <= sa_b_d;
      cin_q   <= cin_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sa_en     = en_q;
  assign sa_WrEn   = wren_q;
  assign sa_Crow   = crow_q;
  assign sa_A      = sa_a_q;
  assign sa_B      = sa_b_q;
  assign sa_Cin    = cin_q;
  assign res_valid = rv_q;
  assign res_row   = rrow_q;
  assign res_data  = rdata_q;
endmodule
